// File: rtl/crush_defs.sv
// rtl/crush_defs.sv - shared fetch-stage constants, FSM encoding and buffer entry type
package crush_defs;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        FS_REQ     = 2'd0,
        FS_DISCARD = 2'd1,
        FS_HALT    = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
        logic            misaligned;
    } fetch_entry_t;

    function automatic logic pc_misaligned(input logic [XLEN-1:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/inst_fetch_buffer.sv
// rtl/inst_fetch_buffer.sv - 2-entry fetch output FIFO; slot 0 is the head seen by decode
module inst_fetch_buffer
    import crush_defs::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         flush,
    output logic [1:0]   count,
    output fetch_entry_t head
);

    localparam fetch_entry_t RESET_ENTRY = '{inst: NOP_INST, pc: RESET_PC, misaligned: 1'b0};

    fetch_entry_t r_slot0;
    fetch_entry_t r_slot1;
    logic [1:0]   r_count;

    logic w_pop;
    logic w_push;

    // Pop is only honoured when non-empty, push only when a slot is (or becomes) free.
    assign w_pop  = pop && (r_count != 2'd0);
    assign w_push = push && ((r_count != 2'd2) || w_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= 2'd0;
            r_slot0 <= RESET_ENTRY;
            r_slot1 <= RESET_ENTRY;
        end else if (flush) begin
            r_count <= 2'd0;
        end else if (w_push && w_pop) begin
            if (r_count == 2'd2) begin
                r_slot0 <= r_slot1;
                r_slot1 <= push_entry;
            end else begin
                r_slot0 <= push_entry;
            end
        end else if (w_push) begin
            if (r_count == 2'd0) begin
                r_slot0 <= push_entry;
            end else begin
                r_slot1 <= push_entry;
            end
            r_count <= r_count + 2'd1;
        end else if (w_pop) begin
            r_slot0 <= r_slot1;
            r_count <= r_count - 2'd1;
        end
    end

    assign count = r_count;
    assign head  = r_slot0;

endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - fetch stage: PC, single-outstanding imem request FSM, redirect flush
module inst_fetch
    import crush_defs::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    output logic            fetch_misaligned
);

    fetch_state_t    r_state;
    fetch_state_t    w_state_next;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_next;
    logic [XLEN-1:0] r_hold_addr;
    logic [XLEN-1:0] w_hold_addr_next;

    logic            w_req;
    logic [XLEN-1:0] w_addr;
    logic            w_push;
    fetch_entry_t    w_push_entry;
    logic            w_pop;
    logic            w_free;
    logic [1:0]      w_count;
    fetch_entry_t    w_head;

    inst_fetch_buffer #(
        .RESET_PC (RESET_PC)
    ) u_buffer (
        .clk        (clk),
        .reset      (reset),
        .push       (w_push),
        .push_entry (w_push_entry),
        .pop        (w_pop),
        .flush      (redirect_valid),
        .count      (w_count),
        .head       (w_head)
    );

    assign inst_valid = (w_count != 2'd0);
    // A redirect supersedes any same-cycle handshake, so it must not pop.
    assign w_pop      = inst_valid && inst_ready && !redirect_valid;
    assign w_free     = (w_count != 2'd2) || w_pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= FS_REQ;
            r_pc        <= RESET_PC;
            r_hold_addr <= RESET_PC;
        end else begin
            r_state     <= w_state_next;
            r_pc        <= w_pc_next;
            r_hold_addr <= w_hold_addr_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_pc_next        = r_pc;
        w_hold_addr_next = r_hold_addr;
        w_req            = 1'b0;
        w_addr           = r_pc;
        w_push           = 1'b0;
        w_push_entry     = '{inst: imem_rdata, pc: r_pc, misaligned: 1'b0};

        case (r_state)
            FS_REQ: begin
                if (!pc_misaligned(r_pc)) begin
                    w_req = w_free;
                    if (w_req && imem_ack) begin
                        w_push    = 1'b1;
                        w_pc_next = r_pc + 32'd4;
                    end
                end else if (w_free) begin
                    // Misaligned target: report it once as a NOP and stop fetching.
                    w_push       = 1'b1;
                    w_push_entry = '{inst: NOP_INST, pc: r_pc, misaligned: 1'b1};
                    w_state_next = FS_HALT;
                end
            end
            FS_DISCARD: begin
                w_req  = 1'b1;
                w_addr = r_hold_addr;
                if (imem_ack) begin
                    w_state_next = FS_REQ;
                end
            end
            FS_HALT: begin
                w_req = 1'b0;
            end
            default: begin
                w_state_next = FS_REQ;
            end
        endcase

        if (redirect_valid) begin
            w_push    = 1'b0;
            w_pc_next = redirect_pc;
            if (w_req && !imem_ack) begin
                w_state_next     = FS_DISCARD;
                w_hold_addr_next = w_addr;
            end else begin
                w_state_next = FS_REQ;
            end
        end
    end

    assign imem_req         = w_req && !reset;
    assign imem_addr        = w_addr;
    assign inst             = w_head.inst;
    assign inst_pc          = w_head.pc;
    assign fetch_misaligned = w_head.misaligned;

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - directed scoreboard bench for inst_fetch with a latency-configurable memory
module tb_inst_fetch;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] SALT = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        inst_valid;
    logic        inst_ready = 1'b1;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        fetch_misaligned;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        mis;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] out_log[$];

    int          n_checks = 0;
    int          n_fail = 0;
    int          mem_lat = 0;
    int          mem_wait = 0;
    bit          prev_pending = 0;
    logic [31:0] prev_addr = 32'h0;
    logic [31:0] m_pc = 32'h0;
    logic [31:0] m_disc_addr = 32'h0;
    bit          m_discard = 0;
    bit          m_halt = 0;
    bit          tb_ready = 1;

    inst_fetch dut (
        .clk              (clk),
        .reset            (reset),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_ack         (imem_ack),
        .imem_rdata       (imem_rdata),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .inst_valid       (inst_valid),
        .inst_ready       (inst_ready),
        .inst             (inst),
        .inst_pc          (inst_pc),
        .fetch_misaligned (fetch_misaligned)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] log_at(input int idx);
        if (idx < out_log.size()) return out_log[idx];
        return 32'hDEAD_BEEF;
    endfunction

    // One clock cycle, entered and left just after a falling edge.
    task automatic cycle(input bit rdir, input logic [31:0] rpc);
        bit   pend;
        exp_t e;
        redirect_valid = rdir;
        redirect_pc    = rpc;
        inst_ready     = tb_ready;
        imem_ack       = 1'b0;
        #1;
        if (imem_req && mem_wait >= mem_lat) begin
            imem_ack   = 1'b1;
            imem_rdata = imem_addr ^ SALT;
        end
        #1;
        if (m_halt && !m_discard) check("halt_no_req", imem_req, 0);
        if (imem_req && prev_pending) check("addr_stable", imem_addr, prev_addr);
        if (inst_valid) begin
            check("out_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                check("inst", inst, sb[0].inst);
                check("inst_pc", inst_pc, sb[0].pc);
                check("misaligned", fetch_misaligned, sb[0].mis);
                if (inst_ready && !rdir) begin
                    e = sb.pop_front();
                    out_log.push_back(e.pc);
                end
            end
        end
        if (imem_req && imem_ack) begin
            if (m_discard) check("discard_addr", imem_addr, m_disc_addr);
            else           check("fetch_addr", imem_addr, m_pc);
            if (!rdir) begin
                if (m_discard) begin
                    m_discard = 0;
                end else begin
                    e = '{m_pc ^ SALT, m_pc, 1'b0};
                    sb.push_back(e);
                    m_pc = m_pc + 32'd4;
                end
            end
        end
        if (rdir) begin
            sb.delete();
            if (imem_req && !imem_ack) begin
                if (!m_discard) m_disc_addr = m_pc;
                m_discard = 1;
            end else begin
                m_discard = 0;
            end
            m_pc   = rpc;
            m_halt = (rpc[1:0] != 2'b00);
            if (m_halt) begin
                e = '{NOP, rpc, 1'b1};
                sb.push_back(e);
            end
        end
        pend         = imem_req && !imem_ack;
        prev_pending = pend;
        prev_addr    = imem_addr;
        @(posedge clk);
        mem_wait = pend ? mem_wait + 1 : 0;
        #1;
        redirect_valid = 1'b0;
        imem_ack       = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        imem_ack       = 1'b0;
        redirect_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_req", imem_req, 0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid", inst_valid, 0);
        check("rst_inst", inst, NOP);
        check("rst_pc", inst_pc, 32'h0);
        check("rst_mis", fetch_misaligned, 0);
        sb.delete();
        out_log.delete();
        m_pc         = 32'h0;
        m_discard    = 0;
        m_halt       = 0;
        mem_wait     = 0;
        prev_pending = 0;
        reset        = 1'b0;
        #1;
        check("first_req", imem_req, 1);
        check("first_addr", imem_addr, 32'h0);
    endtask

    initial begin
        int  mark;
        bit  found;
        @(negedge clk);

        // Zero-wait memory, decode always ready.
        tb_ready = 1;
        mem_lat  = 0;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            check("t1_req_held", imem_req, 1);
            cycle(0, 32'h0);
        end
        check("t1_count", out_log.size(), 11);
        check("t1_last_pc", log_at(10), 32'h28);

        // Three-cycle memory latency.
        mem_lat = 3;
        repeat (8) cycle(0, 32'h0);
        mark = out_log.size();
        repeat (12) cycle(0, 32'h0);
        check("t2_rate", out_log.size() - mark, 3);

        // Decode stall fills the buffer.
        mem_lat  = 0;
        tb_ready = 0;
        repeat (6) cycle(0, 32'h0);
        check("t3_req_low", imem_req, 0);
        check("t3_valid", inst_valid, 1);
        tb_ready = 1;
        for (int i = 0; i < 6; i++) begin
            check("t3_no_gap", inst_valid, 1);
            cycle(0, 32'h0);
        end

        // Redirect while the request for 0x8 is waiting.
        mem_lat = 3;
        do_reset();
        for (int i = 0; i < 40 && !(imem_req && imem_addr == 32'h8 && mem_wait == 1); i++)
            cycle(0, 32'h0);
        found = imem_req && imem_addr == 32'h8 && mem_wait == 1;
        check("t4_pending8", found, 1);
        mark = out_log.size();
        cycle(1, 32'h100);
        for (int i = 0; i < 30 && out_log.size() <= mark; i++) cycle(0, 32'h0);
        check("t4_first_pc", log_at(mark), 32'h100);

        // Misaligned redirect halts fetch until the next redirect.
        mem_lat = 0;
        mark = out_log.size();
        cycle(1, 32'h102);
        repeat (8) cycle(0, 32'h0);
        check("t5_mis_out", log_at(mark), 32'h102);
        check("t5_one_out", out_log.size() - mark, 1);
        check("t5_req_low", imem_req, 0);
        mark = out_log.size();
        cycle(1, 32'h200);
        for (int i = 0; i < 20 && out_log.size() <= mark; i++) cycle(0, 32'h0);
        check("t5_resume_pc", log_at(mark), 32'h200);

        // Redirect in the same cycle as an ack.
        repeat (3) cycle(0, 32'h0);
        check("t6_req_before", imem_req, 1);
        cycle(1, 32'h300);
        check("t6_req_after", imem_req, 1);
        check("t6_addr_after", imem_addr, 32'h300);
        repeat (4) cycle(0, 32'h0);

        // Reset while a request is waiting.
        mem_lat = 3;
        repeat (2) cycle(0, 32'h0);
        check("t6_wait_pending", imem_req, 1);
        do_reset();
        repeat (10) cycle(0, 32'h0);
        check("t6_restart_pc", log_at(0), 32'h0);

        // PC wrap-around.
        mem_lat = 0;
        mark = out_log.size();
        cycle(1, 32'hFFFF_FFF8);
        for (int i = 0; i < 20 && out_log.size() < mark + 3; i++) cycle(0, 32'h0);
        check("t6_wrap0", log_at(mark), 32'hFFFF_FFF8);
        check("t6_wrap1", log_at(mark + 1), 32'hFFFF_FFFC);
        check("t6_wrap2", log_at(mark + 2), 32'h0000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
